// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode definitions: opcode/funct constants, ALU operation
// codes (also used by the ALU) and the control-field decode function.
package decode_stage_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int RAW   = 5;

    // Major opcodes handled by this stage
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // funct3 values shared by OP and OP-IMM
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct7 values: BASE is the plain op, ALT selects SUB / SRA
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    // Control fields derived purely from the instruction word
    typedef struct packed {
        alu_op_e aluoper;
        logic    selopr2;
        logic    rd_wen;
        logic    illegal;
        logic    imm_is_shamt;
    } dec_ctrl_t;

    // funct3 to ALU op; alt picks SUB for 000 and SRA for 101
    function automatic alu_op_e f3_to_alu(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

    // Full control decode. Illegal encodings collapse to a harmless ADD with
    // no register write so execute can simply drop them.
    function automatic dec_ctrl_t decode_ctrl(input logic [31:0] instr);
        dec_ctrl_t  d;
        logic [6:0] opcode;
        logic [2:0] f3;
        logic [6:0] f7;
        opcode         = instr[6:0];
        f3             = instr[14:12];
        f7             = instr[31:25];
        d.aluoper      = ALU_ADD;
        d.selopr2      = 1'b0;
        d.rd_wen       = 1'b0;
        d.illegal      = 1'b0;
        d.imm_is_shamt = 1'b0;
        case (opcode)
            OPC_OP: begin
                d.rd_wen = 1'b1;
                if (f7 == F7_BASE) begin
                    d.aluoper = f3_to_alu(f3, 1'b0);
                end else if (f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA)) begin
                    d.aluoper = f3_to_alu(f3, 1'b1);
                end else begin
                    d.illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                d.selopr2 = 1'b1;
                d.rd_wen  = 1'b1;
                if (f3 == F3_SLL) begin
                    d.imm_is_shamt = 1'b1;
                    if (f7 == F7_BASE) d.aluoper = ALU_SLL;
                    else               d.illegal = 1'b1;
                end else if (f3 == F3_SRL_SRA) begin
                    d.imm_is_shamt = 1'b1;
                    if (f7 == F7_BASE)     d.aluoper = ALU_SRL;
                    else if (f7 == F7_ALT) d.aluoper = ALU_SRA;
                    else                   d.illegal = 1'b1;
                end else begin
                    // no SUBI: funct3 000 is always ADD here
                    d.aluoper = f3_to_alu(f3, 1'b0);
                end
            end
            default: d.illegal = 1'b1;
        endcase
        if (d.illegal) begin
            d.aluoper      = ALU_ADD;
            d.selopr2      = 1'b0;
            d.rd_wen       = 1'b0;
            d.imm_is_shamt = 1'b0;
        end
        return d;
    endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, x0 hardwired to zero, write-first bypass on both reads.
module decode_stage_reg_file
    import decode_stage_pkg::*;
#(
    parameter int XLEN_P  = XLEN,
    parameter int NREGS_P = NREGS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [RAW-1:0]    waddr,
    input  logic [XLEN_P-1:0] wdata,
    input  logic [RAW-1:0]    raddr1,
    output logic [XLEN_P-1:0] rdata1,
    input  logic [RAW-1:0]    raddr2,
    output logic [XLEN_P-1:0] rdata2
);

    logic [XLEN_P-1:0] mem [0:NREGS_P-1];

    // Storage: cleared on reset, writes to x0 are dropped
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS_P; i++) begin
                mem[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports: x0 reads zero, a same-cycle write to the read address wins
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != '0) begin
            rdata1 = (we && waddr == raddr1) ? wdata : mem[raddr1];
        end
        if (raddr2 != '0) begin
            rdata2 = (we && waddr == raddr2) ? wdata : mem[raddr2];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage feeding the ALU from a single registered output slot.
// Optional statistics counters are built when DECODE_STATS_EN is defined;
// otherwise cnt_decoded/cnt_illegal are tied to zero.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN_P  = XLEN,
    parameter int NREGS_P = NREGS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [RAW-1:0]    wb_addr,
    input  logic [XLEN_P-1:0] wb_data,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [XLEN_P-1:0] rdatain1,
    output logic [XLEN_P-1:0] rdatain2,
    output logic [XLEN_P-1:0] dataimmed,
    output logic              selopr2,
    output logic [3:0]        aluoper,
    output logic [RAW-1:0]    rd_addr,
    output logic              rd_wen,
    output logic              illegal,
    output logic [31:0]       cnt_decoded,
    output logic [31:0]       cnt_illegal
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // Upstream: instr is taken when instr_valid && instr_ready && !flush;
    // instr_ready is high whenever the slot is empty or being drained.
    // Downstream: the slot is consumed when dec_valid && dec_ready; all slot
    // fields stay stable while dec_valid && !dec_ready, except that operands
    // are refreshed by matching writebacks.

    logic [RAW-1:0]    rs1;
    logic [RAW-1:0]    rs2;
    logic [XLEN_P-1:0] rf_rdata1;
    logic [XLEN_P-1:0] rf_rdata2;
    logic [XLEN_P-1:0] imm_next;
    logic [RAW-1:0]    held_rs1;
    logic [RAW-1:0]    held_rs2;
    logic              capture;
    dec_ctrl_t         ctrl;

    assign rs1         = instr[19:15];
    assign rs2         = instr[24:20];
    assign instr_ready = !dec_valid || dec_ready;
    assign capture     = instr_valid && instr_ready && !flush;
    assign ctrl        = decode_ctrl(instr);

    decode_stage_reg_file #(
        .XLEN_P  (XLEN_P),
        .NREGS_P (NREGS_P)
    ) u_reg_file (
        .clock  (clock),
        .reset  (reset),
        .we     (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (rs1),
        .rdata1 (rf_rdata1),
        .raddr2 (rs2),
        .rdata2 (rf_rdata2)
    );

    // Immediate: zero-extended shamt for shifts, sign-extended I-imm otherwise
    always_comb begin
        imm_next = '0;
        if (ctrl.selopr2) begin
            if (ctrl.imm_is_shamt) begin
                imm_next = {{(XLEN_P-5){1'b0}}, instr[24:20]};
            end else begin
                imm_next = {{(XLEN_P-12){instr[31]}}, instr[31:20]};
            end
        end
    end

    // Output slot: flush beats capture, capture beats drain, refresh while held
    always_ff @(posedge clock) begin
        if (reset) begin
            dec_valid <= 1'b0;
            rdatain1  <= '0;
            rdatain2  <= '0;
            dataimmed <= '0;
            selopr2   <= 1'b0;
            aluoper   <= ALU_ADD;
            rd_addr   <= '0;
            rd_wen    <= 1'b0;
            illegal   <= 1'b0;
            held_rs1  <= '0;
            held_rs2  <= '0;
        end else if (flush) begin
            dec_valid <= 1'b0;
        end else if (capture) begin
            dec_valid <= 1'b1;
            rdatain1  <= rf_rdata1;
            rdatain2  <= rf_rdata2;
            dataimmed <= imm_next;
            selopr2   <= ctrl.selopr2;
            aluoper   <= ctrl.aluoper;
            rd_addr   <= instr[11:7];
            rd_wen    <= ctrl.rd_wen;
            illegal   <= ctrl.illegal;
            held_rs1  <= rs1;
            held_rs2  <= rs2;
        end else if (dec_valid && dec_ready) begin
            dec_valid <= 1'b0;
        end else if (dec_valid) begin
            if (wb_en && wb_addr != '0 && wb_addr == held_rs1) begin
                rdatain1 <= wb_data;
            end
            if (wb_en && wb_addr != '0 && wb_addr == held_rs2) begin
                rdatain2 <= wb_data;
            end
        end
    end

`ifdef DECODE_STATS_EN
    logic [31:0] cnt_decoded_q;
    logic [31:0] cnt_illegal_q;

    // Statistics: count every capture and every illegal capture, wrapping
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_decoded_q <= '0;
            cnt_illegal_q <= '0;
        end else if (capture) begin
            cnt_decoded_q <= cnt_decoded_q + 32'd1;
            if (ctrl.illegal) begin
                cnt_illegal_q <= cnt_illegal_q + 32'd1;
            end
        end
    end

    assign cnt_decoded = cnt_decoded_q;
    assign cnt_illegal = cnt_illegal_q;
`else
    assign cnt_decoded = '0;
    assign cnt_illegal = '0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: reset check, a table of decode
// vectors, then hand-written bypass/refresh/x0/flush/reset sequences.
module tb_decode_stage;

  logic        clock;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] rdatain1;
  logic [31:0] rdatain2;
  logic [31:0] dataimmed;
  logic        selopr2;
  logic [3:0]  aluoper;
  logic [4:0]  rd_addr;
  logic        rd_wen;
  logic        illegal;
  logic [31:0] cnt_decoded;
  logic [31:0] cnt_illegal;

  int checks;
  int errors;
  int unsigned m_dec;
  int unsigned m_ill;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic        sel;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } vec_t;

  vec_t vq[$];

  decode_stage dut (
    .clock       (clock),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .flush       (flush),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .rdatain1    (rdatain1),
    .rdatain2    (rdatain2),
    .dataimmed   (dataimmed),
    .selopr2     (selopr2),
    .aluoper     (aluoper),
    .rd_addr     (rd_addr),
    .rd_wen      (rd_wen),
    .illegal     (illegal),
    .cnt_decoded (cnt_decoded),
    .cnt_illegal (cnt_illegal)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // advance past the next rising edge; outputs are sampled here
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int unsigned m);
`ifdef DECODE_STATS_EN
    return m;
`else
    return (m == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic chk_counters(input string name);
    chk({name, ".cnt_decoded"}, cnt_decoded, exp_cnt(m_dec));
    chk({name, ".cnt_illegal"}, cnt_illegal, exp_cnt(m_ill));
  endtask

  task automatic add_vec(input string name, input logic [31:0] w, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] imm, input logic sel,
                         input logic [3:0] op, input logic [4:0] rd, input logic wen,
                         input logic ill);
    vec_t v;
    v.name = name; v.instr = w; v.r1 = r1; v.r2 = r2; v.imm = imm;
    v.sel = sel; v.op = op; v.rd = rd; v.wen = wen; v.ill = ill;
    vq.push_back(v);
  endtask

  // driver: one writeback cycle with no instruction offered
  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, ".dec_valid"}, {31'd0, dec_valid}, 32'd0);
    chk({name, ".rdatain1"}, rdatain1, 32'd0);
    chk({name, ".rdatain2"}, rdatain2, 32'd0);
    chk({name, ".dataimmed"}, dataimmed, 32'd0);
    chk({name, ".selopr2"}, {31'd0, selopr2}, 32'd0);
    chk({name, ".aluoper"}, {28'd0, aluoper}, 32'd0);
    chk({name, ".rd_addr"}, {27'd0, rd_addr}, 32'd0);
    chk({name, ".rd_wen"}, {31'd0, rd_wen}, 32'd0);
    chk({name, ".illegal"}, {31'd0, illegal}, 32'd0);
    chk({name, ".cnt_decoded"}, cnt_decoded, 32'd0);
    chk({name, ".cnt_illegal"}, cnt_illegal, 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0; m_dec = 0; m_ill = 0;
    reset = 1'b1; instr_valid = 1'b0; instr = '0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; dec_ready = 1'b1;

    // name, instr, r1, r2, imm, sel, op, rd, wen, ill   (x1=0x10, x2=0x20)
    add_vec("add",    32'h002081B3, 32'h10, 32'h20, 32'h0,        1'b0, 4'd0, 5'd3,  1'b1, 1'b0);
    add_vec("addi",   32'hFFE08293, 32'h10, 32'h0,  32'hFFFFFFFE, 1'b1, 4'd0, 5'd5,  1'b1, 1'b0);
    add_vec("srai",   32'h4040D313, 32'h10, 32'h0,  32'h4,        1'b1, 4'd7, 5'd6,  1'b1, 1'b0);
    add_vec("sub",    32'h401103B3, 32'h20, 32'h10, 32'h0,        1'b0, 4'd1, 5'd7,  1'b1, 1'b0);
    add_vec("sltu",   32'h0020B433, 32'h10, 32'h20, 32'h0,        1'b0, 4'd9, 5'd8,  1'b1, 1'b0);
    add_vec("xori",   32'hFFF14493, 32'h20, 32'h0,  32'hFFFFFFFF, 1'b1, 4'd4, 5'd9,  1'b1, 1'b0);
    add_vec("slli31", 32'h01F11513, 32'h20, 32'h0,  32'h1F,       1'b1, 4'd5, 5'd10, 1'b1, 1'b0);
    add_vec("bad_slli", 32'h41F11513, 32'h20, 32'h0, 32'h0,       1'b0, 4'd0, 5'd0,  1'b0, 1'b1);
    add_vec("bad_and",  32'h4020F5B3, 32'h10, 32'h20, 32'h0,      1'b0, 4'd0, 5'd0,  1'b0, 1'b1);
    add_vec("zero_word", 32'h00000000, 32'h0, 32'h0, 32'h0,       1'b0, 4'd0, 5'd0,  1'b0, 1'b1);
    add_vec("or",     32'h0020E633, 32'h10, 32'h20, 32'h0,        1'b0, 4'd3, 5'd12, 1'b1, 1'b0);
    add_vec("srl",    32'h0020D6B3, 32'h10, 32'h20, 32'h0,        1'b0, 4'd6, 5'd13, 1'b1, 1'b0);
    add_vec("slti",   32'h0050A713, 32'h10, 32'h0,  32'h5,        1'b1, 4'd8, 5'd14, 1'b1, 1'b0);
    add_vec("andi",   32'h7FF17793, 32'h20, 32'h0,  32'h7FF,      1'b1, 4'd2, 5'd15, 1'b1, 1'b0);

    // reset state
    tick();
    tick();
    chk_zero_outputs("reset");
    reset = 1'b0;
    #1;
    chk("reset.instr_ready", {31'd0, instr_ready}, 32'd1);

    wb_write(5'd1, 32'h10);
    wb_write(5'd2, 32'h20);

    // table-driven decode, back-to-back captures with dec_ready high
    for (int i = 0; i < vq.size(); i++) begin
      instr_valid = 1'b1; instr = vq[i].instr; dec_ready = 1'b1;
      tick();
      instr_valid = 1'b0;
      m_dec++;
      if (vq[i].ill) m_ill++;
      chk({vq[i].name, ".dec_valid"}, {31'd0, dec_valid}, 32'd1);
      chk({vq[i].name, ".rdatain1"}, rdatain1, vq[i].r1);
      chk({vq[i].name, ".rdatain2"}, rdatain2, vq[i].r2);
      chk({vq[i].name, ".dataimmed"}, dataimmed, vq[i].imm);
      chk({vq[i].name, ".selopr2"}, {31'd0, selopr2}, {31'd0, vq[i].sel});
      chk({vq[i].name, ".aluoper"}, {28'd0, aluoper}, {28'd0, vq[i].op});
      chk({vq[i].name, ".rd_wen"}, {31'd0, rd_wen}, {31'd0, vq[i].wen});
      chk({vq[i].name, ".illegal"}, {31'd0, illegal}, {31'd0, vq[i].ill});
      if (!vq[i].ill) chk({vq[i].name, ".rd_addr"}, {27'd0, rd_addr}, {27'd0, vq[i].rd});
      chk_counters(vq[i].name);
    end
    tick();
    chk("drain.dec_valid", {31'd0, dec_valid}, 32'd0);

    // write-first bypass: capture ADD x3,x1,x2 while x1 is written
    instr_valid = 1'b1; instr = 32'h002081B3; dec_ready = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h55;
    tick();
    instr_valid = 1'b0; wb_en = 1'b0; m_dec++;
    chk("bypass.dec_valid", {31'd0, dec_valid}, 32'd1);
    chk("bypass.rdatain1", rdatain1, 32'h55);
    chk("bypass.rdatain2", rdatain2, 32'h20);

    // hold: offered SUB must not be taken while slot is stalled
    dec_ready = 1'b0; instr_valid = 1'b1; instr = 32'h401103B3;
    #1;
    chk("hold.instr_ready", {31'd0, instr_ready}, 32'd0);
    tick();
    instr_valid = 1'b0;
    chk("hold.aluoper", {28'd0, aluoper}, 32'd0);
    chk("hold.rd_addr", {27'd0, rd_addr}, 32'd3);
    chk("hold.rdatain1", rdatain1, 32'h55);

    // refresh of held rs2 by writeback
    wb_write(5'd2, 32'h99);
    chk("refresh.dec_valid", {31'd0, dec_valid}, 32'd1);
    chk("refresh.rdatain2", rdatain2, 32'h99);
    chk("refresh.rdatain1", rdatain1, 32'h55);
    chk("refresh.aluoper", {28'd0, aluoper}, 32'd0);
    chk("refresh.rd_addr", {27'd0, rd_addr}, 32'd3);
    chk("refresh.instr_ready", {31'd0, instr_ready}, 32'd0);
    wb_write(5'd7, 32'h77);
    chk("norefresh.rdatain1", rdatain1, 32'h55);
    chk("norefresh.rdatain2", rdatain2, 32'h99);
    dec_ready = 1'b1;
    tick();
    chk("release.dec_valid", {31'd0, dec_valid}, 32'd0);

    // x0: earlier write ignored, same-cycle write not bypassed
    wb_write(5'd0, 32'hFFFF);
    instr_valid = 1'b1; instr = 32'h000001B3;
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
    tick();
    instr_valid = 1'b0; wb_en = 1'b0; m_dec++;
    chk("x0.rdatain1", rdatain1, 32'h0);
    chk("x0.rdatain2", rdatain2, 32'h0);
    chk_counters("x0");

    // flush with simultaneous capture: dropped, counters unchanged
    instr_valid = 1'b1; instr = 32'h002081B3; flush = 1'b1;
    tick();
    instr_valid = 1'b0; flush = 1'b0;
    chk("flush_cap.dec_valid", {31'd0, dec_valid}, 32'd0);
    chk_counters("flush_cap");

    // flush of a held slot
    dec_ready = 1'b0; instr_valid = 1'b1; instr = 32'h002081B3;
    tick();
    instr_valid = 1'b0; m_dec++;
    chk("flush_held.pre", {31'd0, dec_valid}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_held.dec_valid", {31'd0, dec_valid}, 32'd0);
    chk_counters("flush_held");

    // reset mid-operation: slot dropped, register file cleared
    instr_valid = 1'b1; instr = 32'h002081B3;
    tick();
    instr_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0; m_dec = 0; m_ill = 0;
    chk_zero_outputs("midreset");
    dec_ready = 1'b1; instr_valid = 1'b1; instr = 32'h002081B3;
    tick();
    instr_valid = 1'b0; m_dec++;
    chk("post_reset.dec_valid", {31'd0, dec_valid}, 32'd1);
    chk("post_reset.rdatain1", rdatain1, 32'h0);
    chk("post_reset.rdatain2", rdatain2, 32'h0);
    chk_counters("post_reset");

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
